// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page (LED, synchronized switches, cycle timer).
// The timer block (CNT/CMP/STAT and irq) exists only when DMEM_TIMER_EN is defined.
module dmem_responder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq
);
    localparam logic [13:0] OFF_LED  = 14'd0;
    localparam logic [13:0] OFF_SW   = 14'd1;
    localparam logic [13:0] OFF_CNT  = 14'd2;
    localparam logic [13:0] OFF_CMP  = 14'd3;
    localparam logic [13:0] OFF_STAT = 14'd4;

    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [15:0]           r_led;
    logic [15:0]           r_sw_meta;
    logic [15:0]           r_sw_sync;
    logic                  w_is_mmio;
    logic                  w_mmio_we;
    logic [13:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_cnt_rd;
    logic [31:0]           w_cmp_rd;
    logic                  w_stat_rd;
    logic                  w_unused_addr;

    assign w_is_mmio     = (addr[31:16] == 16'hFFFF);
    assign w_mmio_we     = memwrite && w_is_mmio;
    assign w_off         = addr[15:2];
    assign w_idx         = addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^addr[1:0];
    assign led           = r_led;

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (memwrite && !w_is_mmio) begin
            r_mem[w_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_mmio_we && w_off == OFF_LED) begin
                r_led <= wdata[15:0];
            end
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic        r_stat;

    // Match compares the pre-increment count and takes priority over a W1C clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_cmp  <= '1;
            r_stat <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_mmio_we && w_off == OFF_CMP) begin
                r_cmp <= wdata;
            end
            if (r_cnt == r_cmp) begin
                r_stat <= 1'b1;
            end else if (w_mmio_we && w_off == OFF_STAT && wdata[0]) begin
                r_stat <= 1'b0;
            end
        end
    end

    assign w_cnt_rd  = r_cnt;
    assign w_cmp_rd  = r_cmp;
    assign w_stat_rd = r_stat;
    assign irq       = r_stat;
`else
    assign w_cnt_rd  = '0;
    assign w_cmp_rd  = '0;
    assign w_stat_rd = 1'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (w_is_mmio) begin
            case (w_off)
                OFF_LED:  rdata = {16'h0000, r_led};
                OFF_SW:   rdata = {16'h0000, r_sw_sync};
                OFF_CNT:  rdata = w_cnt_rd;
                OFF_CMP:  rdata = w_cmp_rd;
                OFF_STAT: rdata = {31'h0, w_stat_rd};
                default:  rdata = '0;
            endcase
        end else begin
            rdata = r_mem[w_idx];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; timer checks are compiled only with DMEM_TIMER_EN.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          q_kind [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];
    logic [31:0] m_cnt;
    logic [31:0] tgt;
    bit          hit;

`ifdef DMEM_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    dmem_responder #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .memwrite(memwrite), .addr(addr), .wdata(wdata),
        .rdata(rdata), .sw(sw), .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference cycle counter, independent of the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_cnt = 32'd0;
        else      m_cnt = m_cnt + 32'd1;
    end

    // Monitor: everything queued during this cycle is compared at the falling edge.
    always @(negedge clk) begin : monitor
        int          k;
        logic [31:0] e;
        logic [31:0] act;
        string       nm;
        while (q_exp.size() > 0) begin
            k   = q_kind.pop_front();
            e   = q_exp.pop_front();
            nm  = q_name.pop_front();
            act = (k == 0) ? rdata : (k == 1) ? {16'h0, led} : {31'h0, irq};
            n_chk++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got %08h expected %08h", nm, act, e);
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        memwrite = we;
        addr     = a;
        wdata    = d;
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: got timeout expected match within bound", name);
    endtask

    initial begin
        rst = 1'b0; memwrite = 1'b0; addr = 32'hFFFF_000C; wdata = '0; sw = 16'h0000;
        expect_v(1, 32'h0, "reset_led");
        expect_v(2, 32'h0, "reset_irq");
        expect_v(0, TMR ? 32'hFFFF_FFFF : 32'h0, "reset_cmp");
        @(posedge clk); #1; rst = 1'b1;

        // RAM write/read with same-cycle old value and aliasing
        drive(1, 32'h0000_0010, 32'h1111_1111);
        drive(1, 32'h0000_0010, 32'hDEAD_BEEF);
        expect_v(0, 32'h1111_1111, "ram_same_cycle_old");
        drive(0, 32'h0000_0010, 0); expect_v(0, 32'hDEAD_BEEF, "ram_rd_10");
        drive(0, 32'h0000_0013, 0); expect_v(0, 32'hDEAD_BEEF, "ram_rd_13");
        drive(0, 32'h0000_0410, 0); expect_v(0, 32'hDEAD_BEEF, "ram_rd_alias_410");
        drive(1, 32'h0000_0020, 32'h0BAD_F00D);
        drive(0, 32'h0000_0020, 0); expect_v(0, 32'h0BAD_F00D, "ram_rd_20");
        drive(0, 32'h0000_0010, 0); expect_v(0, 32'hDEAD_BEEF, "ram_rd_10_kept");

        // LED register, SW read-only, unmapped offset
        drive(1, 32'hFFFF_0000, 32'h1234_ABCD); expect_v(0, 32'h0, "led_same_cycle_old");
        drive(0, 32'hFFFF_0000, 0);
        expect_v(0, 32'h0000_ABCD, "led_rd");
        expect_v(1, 32'h0000_ABCD, "led_port");
        drive(1, 32'hFFFF_0004, 32'hFFFF_FFFF);
        drive(0, 32'hFFFF_0004, 0);
        expect_v(0, 32'h0, "sw_ro");
        expect_v(1, 32'h0000_ABCD, "led_after_sw_write");
        drive(1, 32'hFFFF_0020, 32'hCAFE_CAFE);
        drive(0, 32'hFFFF_0020, 0); expect_v(0, 32'h0, "unmapped_rd");
        drive(0, 32'hFFFF_0002, 0); expect_v(0, 32'h0000_ABCD, "led_rd_low_bits_ignored");

        // Switch synchronizer: visible after two edges
        drive(0, 32'hFFFF_0004, 0); sw = 16'h5A5A; expect_v(0, 32'h0, "sw_sync_c0");
        drive(0, 32'hFFFF_0004, 0); expect_v(0, 32'h0, "sw_sync_c1");
        drive(0, 32'hFFFF_0004, 0); expect_v(0, 32'h0000_5A5A, "sw_sync_c2");
        drive(0, 32'hFFFF_0004, 0); sw = 16'h0000; expect_v(0, 32'h0000_5A5A, "sw_sync_hold");

        if (TMR) begin
            drive(0, 32'hFFFF_0008, 0); expect_v(0, m_cnt, "cnt_rd");
            drive(0, 32'hFFFF_0008, 0); expect_v(0, m_cnt, "cnt_rd_next");
            tgt = m_cnt + 32'd8;
            drive(1, 32'hFFFF_000C, tgt);
            drive(0, 32'hFFFF_000C, 0); expect_v(0, tgt, "cmp_rd");
            hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                drive(0, 32'hFFFF_0010, 0);
                if (m_cnt == tgt) begin hit = 1'b1; break; end
            end
            if (!hit) timeout_fail("match1_wait");
            expect_v(2, 32'h0, "irq_low_on_match_cycle");
            drive(0, 32'hFFFF_0010, 0);
            expect_v(2, 32'h1, "irq_rise");
            expect_v(0, 32'h1, "stat_rd");
            drive(0, 32'hFFFF_0010, 0); expect_v(2, 32'h1, "irq_sticky");
            drive(1, 32'hFFFF_0010, 32'h1); expect_v(2, 32'h1, "irq_during_w1c");
            drive(0, 32'hFFFF_0010, 0); expect_v(2, 32'h0, "irq_cleared");

            tgt = m_cnt + 32'd6;
            drive(1, 32'hFFFF_000C, tgt);
            hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (m_cnt == tgt) begin
                    memwrite = 1'b1; addr = 32'hFFFF_0010; wdata = 32'h1; hit = 1'b1; break;
                end
                memwrite = 1'b0; addr = 32'hFFFF_0010; wdata = 32'h0;
            end
            if (!hit) timeout_fail("match2_wait");
            drive(0, 32'hFFFF_0010, 0); expect_v(2, 32'h1, "set_beats_clear");
            drive(1, 32'hFFFF_0010, 32'h1);
            drive(0, 32'hFFFF_0010, 0); expect_v(2, 32'h0, "irq_cleared2");

`ifdef DMEM_TIMER_EN
            drive(0, 32'hFFFF_0008, 0);
            force dut.r_cnt = 32'hFFFF_FFFE;
            m_cnt = 32'hFFFF_FFFE;
            #1 release dut.r_cnt;
            expect_v(0, 32'hFFFF_FFFE, "cnt_wrap_fe");
`endif
            drive(0, 32'hFFFF_0008, 0); expect_v(0, 32'hFFFF_FFFF, "cnt_wrap_ff");
            drive(0, 32'hFFFF_0008, 0); expect_v(0, 32'h0000_0000, "cnt_wrap_00");

            tgt = m_cnt + 32'd3;
            drive(1, 32'hFFFF_000C, tgt);
            for (int i = 0; i < 10; i++) drive(0, 32'h0, 0);
        end else begin
            drive(1, 32'hFFFF_0008, 32'h1234_5678);
            drive(1, 32'hFFFF_000C, 32'h0000_0000);
            drive(1, 32'hFFFF_0010, 32'hFFFF_FFFF);
            drive(0, 32'hFFFF_0008, 0); expect_v(0, 32'h0, "notmr_cnt");
            drive(0, 32'hFFFF_000C, 0); expect_v(0, 32'h0, "notmr_cmp");
            drive(0, 32'hFFFF_0010, 0); expect_v(0, 32'h0, "notmr_stat");
            expect_v(2, 32'h0, "notmr_irq");
        end

        // Async reset mid-cycle: registers clear at once, RAM survives
        drive(1, 32'h0000_0010, 32'h0000_0055);
        drive(1, 32'hFFFF_0000, 32'h0000_FFFF);
        drive(0, 32'hFFFF_0000, 0);
        expect_v(1, 32'h0000_FFFF, "led_pre_reset");
        expect_v(2, TMR ? 32'h1 : 32'h0, "irq_pre_reset");
        drive(0, 32'hFFFF_0000, 0);
        #2 rst = 1'b0;
        expect_v(1, 32'h0, "led_async_reset");
        expect_v(2, 32'h0, "irq_async_reset");
        expect_v(0, 32'h0, "led_rd_in_reset");
        drive(0, 32'h0000_0010, 0); expect_v(0, 32'h0000_0055, "ram_kept_in_reset");
        drive(0, 32'hFFFF_0008, 0); expect_v(0, 32'h0, "cnt_in_reset");
        drive(0, 32'hFFFF_000C, 0); expect_v(0, TMR ? 32'hFFFF_FFFF : 32'h0, "cmp_in_reset");
        drive(0, 32'hFFFF_0008, 0); rst = 1'b1; expect_v(0, 32'h0, "cnt_after_release");
        drive(0, 32'hFFFF_0008, 0); expect_v(0, TMR ? 32'h1 : 32'h0, "cnt_release_plus1");
        expect_v(2, 32'h0, "irq_after_release");
        drive(0, 32'h0000_0010, 0); expect_v(0, 32'h0000_0055, "ram_kept_after_reset");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
